mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset.
REQ-003 Instr  in  32  instruction register contents from the datapath.
REQ-004 ALUFlags  in  4  {N,Z,C,V} from the datapath ALU.
REQ-005 PCWrite, RegWrite, MemWrite, IRWrite  out  1 each  write enables.
REQ-006 AdrSrc  out  1  address select: 0 = PC, 1 = Result.
REQ-007 RegSrc  out  2  [0] = 1 selects R15 as RA1; [1] = 1 selects Rd as RA2.
REQ-008 ALUSrcA  out  2  0 = A, 1 = PC, 2 = ALUOut.
REQ-009 ALUSrcB  out  2  0 = WriteData, 1 = ExtImm, 2 = constant 4.
REQ-010 ResultSrc  out  2  0 = ALUOut, 1 = Data, 2 = ALUResult.
REQ-011 ImmSrc, ALUControl  out  2 each  extend mode; ALU op (00 ADD, 01 SUB, 10 AND, 11 ORR).
REQ-012 State  out  4  current FSM state, for visualization.

Function
REQ-013 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH and UNKNOWN.
REQ-014 The FSM SHALL take these transitions, with Op = Instr[27:26]:
- FETCH -> DECODE.
- DECODE -> EXECUTER when Op = 00 and Instr[25] = 0.
- DECODE -> EXECUTEI when Op = 00 and Instr[25] = 1.
- DECODE -> MEMADR when Op = 01.
- DECODE -> BRANCH when Op = 10.
- DECODE -> UNKNOWN when Op = 11.
REQ-015 The FSM SHALL continue as follows:
- MEMADR -> MEMRD when Instr[20] = 1, else MEMADR -> MEMWR.
- MEMRD -> MEMWB -> FETCH.
- MEMWR -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
- UNKNOWN -> FETCH.
REQ-016 FETCH SHALL drive AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 2, ALUControl = 00, ResultSrc = 2 and PCWrite = 1. PCWrite in FETCH is unconditional.
REQ-017 DECODE SHALL drive ALUSrcA = 1, ALUSrcB = 2, ALUControl = 00 and ResultSrc = 2, so that R15 reads PC+8.
REQ-018 MEMADR SHALL drive ALUSrcA = 0, ALUSrcB = 1 and ALUControl = 00.
REQ-019 MEMRD SHALL drive AdrSrc = 1 and ResultSrc = 0.
REQ-020 MEMWB SHALL drive ResultSrc = 1 and RegWrite = CondEx_q.
REQ-021 MEMWR SHALL drive AdrSrc = 1, ResultSrc = 0 and MemWrite = CondEx_q.
REQ-022 EXECUTER SHALL drive ALUSrcA = 0 and ALUSrcB = 0; EXECUTEI SHALL drive ALUSrcA = 0 and ALUSrcB = 1.
REQ-023 ALUWB SHALL drive ResultSrc = 0 and RegWrite = CondEx_q.
REQ-024 ALUWB and MEMWB SHALL additionally drive PCWrite = CondEx_q when Instr[15:12] = 1111.
REQ-025 BRANCH SHALL drive ALUSrcA = 0, ALUSrcB = 1, ALUControl = 00, ResultSrc = 2 and PCWrite = CondEx_q.
REQ-026 In every state, any output not listed SHALL be 0; UNKNOWN SHALL assert no write enable.
REQ-027 The following SHALL be combinational at all times:
- ImmSrc = Op.
- RegSrc = {Op == 01, Op == 10}.
REQ-028 ALUControl in EXECUTER and EXECUTEI SHALL be decoded from Instr[24:21]:
- 0100 -> 00 (ADD).
- 0010 -> 01 (SUB).
- 0000 -> 10 (AND).
- 1100 -> 11 (ORR).
- any other code -> 00, with no flag update.
REQ-029 FlagW SHALL be 00 when Instr[20] = 0. When Instr[20] = 1 it SHALL be 11 for ADD/SUB and 10 for AND/ORR. FlagW is used only in EXECUTER and EXECUTEI.
REQ-030 CondEx SHALL be evaluated from Instr[31:28] against the flags register using full ARM EQ..LE semantics. Code 1110 SHALL give 1; code 1111 SHALL give 0.
REQ-031 CondEx SHALL be registered into CondEx_q at the end of DECODE and held until the next DECODE.
REQ-032 At the end of EXECUTER or EXECUTEI, when CondEx_q = 1, the flags register SHALL load:
- N and Z from ALUFlags[3:2] if FlagW[1] = 1.
- C and V from ALUFlags[1:0] if FlagW[0] = 1.
REQ-033 The flags register SHALL be unchanged in all other states.

Reset
REQ-034 While reset = 0, State SHALL be FETCH, the flags register and CondEx_q SHALL be 0, and PCWrite, RegWrite, MemWrite and IRWrite SHALL be forced to 0.
REQ-035 Reset asserted in any state SHALL abort the instruction with no further write enable. The first FETCH after deassertion SHALL assert IRWrite and PCWrite.

Structure
REQ-036 Package mc_ctrl_pkg SHALL hold:
- the state encoding (4 bits, FETCH = 0).
- ALUControl codes.
- the ALUSrcA, ALUSrcB and ResultSrc select constants.
REQ-037 Condition evaluation and the flags/CondEx_q registers SHALL reside in one sub-module, mc_condlogic.

Verification
REQ-038 ADD R1,R2,R3 (0xE0821003):
- Stimulus: run the instruction from reset.
- Response: states FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegWrite = 1 only in ALUWB; ALUControl = 00 in EXECUTER.
REQ-039 LDR R2,[R1,#4] (0xE5912004):
- Response: states FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc = 1 in MEMRD; RegWrite = 1 only in MEMWB.
REQ-040 STR R2,[R1,#4] (0xE5812004):
- Response: RegSrc = 10; MemWrite = 1 only in MEMWR; RegWrite never asserted.
REQ-041 SUBS R0,R0,R0 (0xE0500000) with ALUFlags = 0100, then BEQ (0x0A000002):
- Response: Z = 1 after EXECUTER; PCWrite = 1 in BRANCH.
- Repeat with ALUFlags = 0000: PCWrite = 0 in BRANCH.
REQ-042 ADDNE R1,R2,R3 (0x10821003) with Z = 1:
- Response: RegWrite = 0 in ALUWB; flags unchanged.
REQ-043 Reset and UNKNOWN:
- Stimulus: reset = 0 while State = MEMRD.
- Response: State = FETCH and all enables 0 immediately; flags = 0000.
- Stimulus: Op = 11.
- Response: states DECODE, UNKNOWN, FETCH with no RegWrite or MemWrite.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_controller shared definitions.
// State encoding, ALU op codes and datapath select constants.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_UNKNOWN  = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCA_REG    = 2'd0;
    localparam logic [1:0] SRCA_PC     = 2'd1;
    localparam logic [1:0] SRCA_ALUOUT = 2'd2;

    localparam logic [1:0] SRCB_WD   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

// File: rtl/mc_condlogic.sv
// Condition evaluation plus the NZCV flags and CondEx_q registers.
// CondEx is sampled in DECODE; flags load only in a taken EXECUTE.
module mc_condlogic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       latch_cond,
    input  logic       flag_upd,
    output logic       cond_ex_q
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_d;
    logic       cond_ex;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // ARM condition code against the current flags
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = !z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = !c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = !n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = !v;
            4'h8: cond_ex = c && !z;
            4'h9: cond_ex = !c || z;
            4'ha: cond_ex = (n == v);
            4'hb: cond_ex = (n != v);
            4'hc: cond_ex = !z && (n == v);
            4'hd: cond_ex = z || (n != v);
            4'he: cond_ex = 1'b1;
            4'hf: cond_ex = 1'b0;
        endcase
    end

    // next flags and latched condition
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = latch_cond ? cond_ex : cond_ex_q;
        if (flag_upd && cond_ex_q) begin
            if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
        end
    end

    // flags and CondEx_q registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control FSM.
// Enables are gated by reset so nothing writes while it is held.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic [1:0] alu_dec;
    logic [1:0] flag_w;
    logic       known;
    logic       cond_ex_q;
    logic       rd_pc;
    logic       pc_w, reg_w, mem_w, ir_w;
    logic       unused_bits;

    assign op          = Instr[27:26];
    assign rd_pc       = (Instr[15:12] == 4'hf);
    assign ImmSrc      = op;
    assign RegSrc      = {op == 2'b01, op == 2'b10};
    assign State       = state_q;
    assign unused_bits = ^{Instr[19:16], Instr[11:0]};

    // data-processing op and flag-write decode
    always_comb begin
        alu_dec = ALU_ADD;
        known   = 1'b1;
        unique case (Instr[24:21])
            4'b0100: alu_dec = ALU_ADD;
            4'b0010: alu_dec = ALU_SUB;
            4'b0000: alu_dec = ALU_AND;
            4'b1100: alu_dec = ALU_ORR;
            default: known = 1'b0;
        endcase
        flag_w = 2'b00;
        if (Instr[20] && known)
            flag_w = alu_dec[1] ? 2'b10 : 2'b11;
    end

    mc_condlogic u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (Instr[31:28]),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .latch_cond (state_q == S_DECODE),
        .flag_upd   (state_q == S_EXECUTER ||
                     state_q == S_EXECUTEI),
        .cond_ex_q  (cond_ex_q)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    2'b00: state_d = Instr[25] ? S_EXECUTEI
                                               : S_EXECUTER;
                    2'b01: state_d = S_MEMADR;
                    2'b10: state_d = S_BRANCH;
                    2'b11: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Instr[20] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // per-state datapath controls
    always_comb begin
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_WD;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = cond_ex_q;
                pc_w      = cond_ex_q && rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = cond_ex_q;
            end
            S_EXECUTER: ALUControl = alu_dec;
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_dec;
            end
            S_ALUWB: begin
                reg_w = cond_ex_q;
                pc_w  = cond_ex_q && rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pc_w      = cond_ex_q;
            end
            default: ;
        endcase
    end

    assign PCWrite  = pc_w  & reset;
    assign RegWrite = reg_w & reset;
    assign MemWrite = mem_w & reset;
    assign IRWrite  = ir_w  & reset;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, reset corner
// case and random instructions against a route-based reference model.
`timescale 1ns/1ps
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [1:0]  ImmSrc, ALUControl;
    logic [3:0]  State;
    logic [20:0] act;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    assign act = {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc,
                  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                  ALUControl, State};

    int vecs = 0;
    int errs = 0;

    logic [3:0] m_nzcv = 4'h0;
    bit         m_cex = 1'b0;
    state_t     m_q[$];

    // ARM condition: even codes are base tests, odd codes invert them
    function automatic bit holds(input logic [3:0] cc,
                                 input logic [3:0] f);
        bit n, z, c, v, b;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0:    b = z;
            3'd1:    b = c;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = c && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return cc[0] ? !b : b;
    endfunction

    function automatic int op_idx(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            default: return -1;
        endcase
    endfunction

    // whole path an instruction takes, from its class
    function automatic void route(input logic [31:0] i);
        m_q.delete();
        m_q.push_back(S_FETCH);
        m_q.push_back(S_DECODE);
        case (i[27:26])
            2'b00: begin
                m_q.push_back(i[25] ? S_EXECUTEI : S_EXECUTER);
                m_q.push_back(S_ALUWB);
            end
            2'b01: begin
                m_q.push_back(S_MEMADR);
                if (i[20]) begin
                    m_q.push_back(S_MEMRD);
                    m_q.push_back(S_MEMWB);
                end else begin
                    m_q.push_back(S_MEMWR);
                end
            end
            2'b10:   m_q.push_back(S_BRANCH);
            default: m_q.push_back(S_UNKNOWN);
        endcase
    endfunction

    function automatic logic [20:0] expect_out(input state_t p,
                                               input logic [31:0] i,
                                               input bit cex);
        logic pcw, rw, mw, irw, adr;
        logic [1:0] sa, sb, rs, ac, op;
        int k;
        bit rd15;
        pcw = 0; rw = 0; mw = 0; irw = 0; adr = 0;
        sa = 0; sb = 0; rs = 0; ac = 0;
        op = i[27:26];
        rd15 = (i[15:12] == 4'hf);
        k = op_idx(i[24:21]);
        case (p)
            S_FETCH: begin
                irw = 1; pcw = 1; sa = 1; sb = 2; rs = 2;
            end
            S_DECODE: begin sa = 1; sb = 2; rs = 2; end
            S_MEMADR: sb = 1;
            S_MEMRD:  adr = 1;
            S_MEMWB: begin rs = 1; rw = cex; pcw = cex && rd15; end
            S_MEMWR: begin adr = 1; mw = cex; end
            S_EXECUTER: ac = (k < 0) ? 2'd0 : 2'(k);
            S_EXECUTEI: begin
                sb = 1; ac = (k < 0) ? 2'd0 : 2'(k);
            end
            S_ALUWB: begin rw = cex; pcw = cex && rd15; end
            S_BRANCH: begin sb = 1; rs = 2; pcw = cex; end
            default: ;
        endcase
        return {pcw, rw, mw, irw, adr, op == 2'b01, op == 2'b10,
                sa, sb, rs, op, ac, 4'(p)};
    endfunction

    // run one instruction from FETCH; entered and left at a negedge
    task automatic run_instr(input logic [31:0] i,
                             input logic [3:0] af, input bit rnd,
                             output int n, output logic [19:0] sts,
                             output logic [4:0] rwm,
                             output logic [4:0] mwm,
                             output logic [4:0] pwm);
        state_t p;
        logic [20:0] exp;
        int k;
        route(i);
        n = 0; sts = '0; rwm = '0; mwm = '0; pwm = '0;
        Instr = i;
        while (m_q.size() > 0) begin
            p = m_q.pop_front();
            ALUFlags = rnd ? 4'($urandom) : af;
            #1;
            exp = expect_out(p, i, m_cex);
            vecs++;
            if (act !== exp) begin
                errs++;
                $display("FAIL %s instr=%h: got %h want %h",
                         p.name(), i, act, exp);
            end
            if (n < 5) begin
                sts[n*4 +: 4] = State;
                rwm[n] = RegWrite;
                mwm[n] = MemWrite;
                pwm[n] = PCWrite;
            end
            n++;
            if (p == S_DECODE) m_cex = holds(i[31:28], m_nzcv);
            if ((p == S_EXECUTER || p == S_EXECUTEI) && m_cex
                && i[20]) begin
                k = op_idx(i[24:21]);
                if (k == 0 || k == 1) m_nzcv = ALUFlags;
                if (k == 2 || k == 3) m_nzcv[3:2] = ALUFlags[3:2];
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [19:0] sq(input state_t a, b, c,
                                       input state_t d = S_FETCH,
                                       input state_t e = S_FETCH);
        return {4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  af;
        int          n;
        logic [19:0] sts;
        logic [4:0]  rw, mw, pw;
    } vec_t;

    vec_t tbl[16];

    task automatic check_table(input int lo, input int hi);
        int n;
        logic [19:0] sts;
        logic [4:0] rw, mw, pw;
        for (int t = lo; t < hi; t++) begin
            run_instr(tbl[t].instr, tbl[t].af, 1'b0,
                      n, sts, rw, mw, pw);
            vecs++;
            if (n != tbl[t].n || sts !== tbl[t].sts ||
                rw !== tbl[t].rw || mw !== tbl[t].mw ||
                pw !== tbl[t].pw) begin
                errs++;
                $display("FAIL row%0d %h: got n=%0d st=%h rw=%b mw=%b pw=%b want n=%0d st=%h rw=%b mw=%b pw=%b",
                         t, tbl[t].instr, n, sts, rw, mw, pw,
                         tbl[t].n, tbl[t].sts, tbl[t].rw,
                         tbl[t].mw, tbl[t].pw);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        vecs++;
        if ({PCWrite, RegWrite, MemWrite, IRWrite, State} !== 8'h0)
        begin
            errs++;
            $display("FAIL %s: got en=%b state=%0d want en=0000 state=0",
                     tag, {PCWrite, RegWrite, MemWrite, IRWrite},
                     State);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [19:0] sts;
        logic [4:0] rw, mw, pw;
        bit hit;

        tbl[0]  = '{32'hE0821003, 4'h0, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b01000, 5'b00000, 5'b00001};
        tbl[1]  = '{32'hE5912004, 4'h0, 5,
                   sq(S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB),
                   5'b10000, 5'b00000, 5'b00001};
        tbl[2]  = '{32'hE5812004, 4'h0, 4,
                   sq(S_FETCH, S_DECODE, S_MEMADR, S_MEMWR),
                   5'b00000, 5'b01000, 5'b00001};
        tbl[3]  = '{32'hE0500000, 4'b0100, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b01000, 5'b00000, 5'b00001};
        tbl[4]  = '{32'h0A000002, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00101};
        tbl[5]  = '{32'h10821003, 4'h0, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b00000, 5'b00000, 5'b00001};
        tbl[6]  = '{32'h10921003, 4'b1011, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b00000, 5'b00000, 5'b00001};
        tbl[7]  = '{32'h0A000002, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00101};
        tbl[8]  = '{32'hE0500000, 4'b0000, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b01000, 5'b00000, 5'b00001};
        tbl[9]  = '{32'h0A000002, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00001};
        tbl[10] = '{32'hEC000000, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_UNKNOWN),
                   5'b00000, 5'b00000, 5'b00001};
        tbl[11] = '{32'hE082F003, 4'h0, 4,
                   sq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB),
                   5'b01000, 5'b00000, 5'b01001};
        tbl[12] = '{32'h05912004, 4'h0, 5,
                   sq(S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB),
                   5'b00000, 5'b00000, 5'b00001};
        tbl[13] = '{32'h1A000000, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00101};
        tbl[14] = '{32'h3A000000, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00101};
        tbl[15] = '{32'h5A000000, 4'h0, 3,
                   sq(S_FETCH, S_DECODE, S_BRANCH),
                   5'b00000, 5'b00000, 5'b00101};

        Instr = 32'hE0821003;
        @(negedge clk);
        check_reset("reset_hold");
        @(negedge clk);
        reset = 1'b1;

        check_table(0, 13);

        // set every flag, then reset mid-LDR; flags must clear
        run_instr(32'hE0500000, 4'b1111, 1'b0, n, sts, rw, mw, pw);
        Instr = 32'hE5912004;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            #1;
            if (State == 4'(S_MEMRD)) hit = 1'b1;
            else @(negedge clk);
        end
        vecs++;
        if (!hit) begin
            errs++;
            $display("FAIL reach_memrd: got state=%0d want %0d",
                     State, 4'(S_MEMRD));
        end
        reset = 1'b0;
        #1;
        check_reset("reset_async");
        m_nzcv = 4'h0;
        m_cex = 1'b0;
        @(negedge clk);
        check_reset("reset_held");
        @(negedge clk);
        reset = 1'b1;

        check_table(13, 16);
        run_instr(32'h7A000000, 4'h0, 1'b0, n, sts, rw, mw, pw);
        vecs++;
        if (pw !== 5'b00101) begin
            errs++;
            $display("FAIL bvc_after_reset: got pw=%b want 00101", pw);
        end

        for (int r = 0; r < 150; r++) begin
            run_instr($urandom, 4'h0, 1'b1, n, sts, rw, mw, pw);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
